// File: rtl/rr_arbiter4_v_pkg.sv
// Shared constants, state encoding and pointer helper for the 4-way round-robin arbiter.
package arb_pkg_v;

  localparam int unsigned N_REQ = 4;
  localparam int unsigned ID_W  = 2;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_e;

  function automatic logic [ID_W-1:0] ptr_inc(input logic [ID_W-1:0] p);
    return p + ID_W'(1);
  endfunction

endpackage

// File: rtl/rr_arbiter4_v_if.sv
// Request/grant bundle between four clients (master) and the arbiter (slave).
interface rr_arbiter4_v_if;
  import arb_pkg_v::*;

  logic [N_REQ-1:0] i_req;
  logic [N_REQ-1:0] o_gnt;
  logic [ID_W-1:0]  o_gnt_id;
  logic             o_busy;
  logic             o_any_req;
  logic             o_timeout;

  modport master (
    output i_req,
    input  o_gnt, o_gnt_id, o_busy, o_any_req, o_timeout
  );

  modport slave (
    input  i_req,
    output o_gnt, o_gnt_id, o_busy, o_any_req, o_timeout
  );

endinterface

// File: rtl/rr_arbiter4_v_pick.sv
// Combinational rotating-priority picker: first set request searching start, start+1, ... mod 4.
module rr_pick4_v
  import arb_pkg_v::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  start,
  output logic [N_REQ-1:0] pick,
  output logic [ID_W-1:0]  idx,
  output logic             any
);

  logic [ID_W-1:0] cand;
  logic            found;

  always_comb begin
    pick  = '0;
    idx   = '0;
    cand  = '0;
    found = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = start + ID_W'(k);
      if (!found && req[cand]) begin
        found      = 1'b1;
        pick[cand] = 1'b1;
        idx        = cand;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/rr_arbiter4_v.sv
// Four-client round-robin arbiter with request/hold/release ownership.
// Optional forced revoke after MAX_HOLD cycles when ARB_TIMEOUT_EN is defined.
module rr_arbiter4_v
  import arb_pkg_v::*;
#(
  parameter int unsigned MAX_HOLD = 16,
  parameter int unsigned HOLD_W   = 8
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  rr_arbiter4_v_if.slave arb
);

  arb_state_e       state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [ID_W-1:0]  id_q, id_d;
  logic [ID_W-1:0]  ptr_q, ptr_d;
  logic             busy_q;
  logic [N_REQ-1:0] masked_req;
  logic [N_REQ-1:0] pick_req, pick_gnt;
  logic [ID_W-1:0]  pick_start, pick_id;
  logic             pick_any;
  logic             revoke;

`ifdef ARB_TIMEOUT_EN
  logic [N_REQ-1:0]  mask_q, mask_d;
  logic [HOLD_W-1:0] cnt_q, cnt_d;
  logic              timeout_q;
  logic              new_grant;

  assign masked_req = arb.i_req & ~mask_q;
  assign revoke     = (state_q == ST_GRANT) && arb.i_req[id_q] &&
                      (cnt_q == HOLD_W'(MAX_HOLD));
  // A mask bit survives only while its client keeps requesting.
  assign mask_d     = (mask_q & arb.i_req) | (revoke ? gnt_q : '0);
  // A handoff always goes to a different client, so any change to a non-zero grant is new.
  assign new_grant  = (gnt_d != '0) && (gnt_d != gnt_q);

  always_comb begin
    cnt_d = cnt_q;
    if (new_grant)         cnt_d = HOLD_W'(1);
    else if (gnt_d == '0)  cnt_d = '0;
    else                   cnt_d = cnt_q + HOLD_W'(1);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      mask_q    <= '0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      mask_q    <= mask_d;
      cnt_q     <= cnt_d;
      timeout_q <= revoke;
    end
  end

  assign arb.o_timeout = timeout_q;
`else
  assign masked_req    = arb.i_req;
  assign revoke        = 1'b0;
  assign arb.o_timeout = 1'b0;
`endif

  rr_pick4_v u_pick (
    .req   (pick_req),
    .start (pick_start),
    .pick  (pick_gnt),
    .idx   (pick_id),
    .any   (pick_any)
  );

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    id_d       = id_q;
    ptr_d      = ptr_q;
    pick_req   = masked_req;
    pick_start = ptr_q;
    unique case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          gnt_d   = pick_gnt;
          id_d    = pick_id;
          state_d = ST_GRANT;
        end
      end
      ST_GRANT: begin
        // Handoff search starts past the owner and never considers the owner itself.
        pick_req   = masked_req & ~gnt_q;
        pick_start = ptr_inc(id_q);
        if (!arb.i_req[id_q] || revoke) begin
          ptr_d = ptr_inc(id_q);
          if (pick_any) begin
            gnt_d = pick_gnt;
            id_d  = pick_id;
          end else begin
            gnt_d   = '0;
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      id_q    <= '0;
      ptr_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      id_q    <= id_d;
      ptr_q   <= ptr_d;
      busy_q  <= |gnt_d;
    end
  end

  assign arb.o_gnt     = gnt_q;
  assign arb.o_gnt_id  = id_q;
  assign arb.o_busy    = busy_q;
  assign arb.o_any_req = |masked_req;

endmodule

// File: tb/tb_rr_arbiter4_v.sv
// Directed bench for rr_arbiter4_v; covers the timeout path when ARB_TIMEOUT_EN is defined.
module tb_rr_arbiter4_v;

  logic clk;
  logic rst_n;
  int   errs;
  int   checks;

  rr_arbiter4_v_if arb_if ();

  rr_arbiter4_v #(
    .MAX_HOLD (4),
    .HOLD_W   (8)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .arb     (arb_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
    checks++;
    if (obs != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one edge and land 1ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_gnt(input string tag, input int unsigned gnt, input int unsigned id);
    check({tag, "_gnt"}, arb_if.o_gnt, gnt);
    check({tag, "_busy"}, arb_if.o_busy, (gnt != 0) ? 1 : 0);
    if (gnt != 0) check({tag, "_id"}, arb_if.o_gnt_id, id);
  endtask

  initial begin
    int order [5];
    int bad_gnt;
    int bad_tmo;
    order   = '{0, 1, 2, 3, 0};
    errs    = 0;
    checks  = 0;
    rst_n   = 1'b0;
    arb_if.i_req = 4'b0000;
    step();
    step();
    rst_n = 1'b1;

    // Reset state
    check("rst_gnt", arb_if.o_gnt, 0);
    check("rst_id", arb_if.o_gnt_id, 0);
    check("rst_busy", arb_if.o_busy, 0);
    check("rst_tmo", arb_if.o_timeout, 0);
    check("rst_any", arb_if.o_any_req, 0);

    // Reset asserted mid-grant clears outputs without a clock edge
    arb_if.i_req = 4'b0001;
    step();
    expect_gnt("mid_pre", 4'b0001, 0);
    step();
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_gnt", arb_if.o_gnt, 0);
    check("mid_rst_busy", arb_if.o_busy, 0);
    arb_if.i_req = 4'b0011;
    #1 rst_n = 1'b1;
    step();
    expect_gnt("mid_after", 4'b0001, 0);
    arb_if.i_req = 4'b0010;
    step();
    expect_gnt("mid_hand", 4'b0010, 1);
    arb_if.i_req = 4'b0000;
    step();
    expect_gnt("mid_idle", 0, 0);
    // ptr is now 2

    // Single request, no contention
    arb_if.i_req = 4'b0100;
    #1 check("single_any", arb_if.o_any_req, 1);
    step();
    expect_gnt("single", 4'b0100, 2);
    arb_if.i_req = 4'b0000;
    step();
    expect_gnt("single_rel", 0, 0);
    // ptr is now 3

    // Wrap-around and no re-win
    arb_if.i_req = 4'b1001;
    step();
    expect_gnt("wrap_3", 4'b1000, 3);
    step();
    expect_gnt("wrap_3_hold", 4'b1000, 3);
    arb_if.i_req = 4'b0001;
    step();
    expect_gnt("wrap_0", 4'b0001, 0);
    arb_if.i_req = 4'b1000;
    step();
    expect_gnt("wrap_back3", 4'b1000, 3);
    arb_if.i_req = 4'b0000;
    step();
    expect_gnt("wrap_idle", 0, 0);
    // ptr is now 0

    // Full contention, each owner releases after 3 grant cycles
    arb_if.i_req = 4'b1111;
    step();
    for (int n = 0; n < 5; n++) begin
      for (int c = 0; c < 3; c++) begin
        expect_gnt($sformatf("rr%0d_c%0d", n, c), 1 << order[n], order[n]);
        if (c < 2) step();
      end
      if (n < 4) arb_if.i_req = 4'b1111 & ~(4'b0001 << order[n]);
      else       arb_if.i_req = 4'b0000;
      step();
      if (n < 4) arb_if.i_req = 4'b1111;
    end
    expect_gnt("rr_idle", 0, 0);
    // ptr is now 1

`ifdef ARB_TIMEOUT_EN
    rst_n = 1'b0;
    #1 rst_n = 1'b1;
    arb_if.i_req = 4'b0011;
    step();
    expect_gnt("to_c1", 4'b0001, 0);
    check("to_c1_tmo", arb_if.o_timeout, 0);
    for (int c = 2; c <= 4; c++) begin
      step();
      expect_gnt($sformatf("to_c%0d", c), 4'b0001, 0);
      check($sformatf("to_c%0d_tmo", c), arb_if.o_timeout, 0);
    end
    step();
    expect_gnt("to_revoke", 4'b0010, 1);
    check("to_pulse", arb_if.o_timeout, 1);
    step();
    expect_gnt("to_after", 4'b0010, 1);
    check("to_pulse_end", arb_if.o_timeout, 0);
    arb_if.i_req = 4'b0001;
    #1 check("to_masked_any", arb_if.o_any_req, 0);
    step();
    expect_gnt("to_masked_idle", 0, 0);
    step();
    expect_gnt("to_masked_still", 0, 0);
    arb_if.i_req = 4'b0000;
    step();
    arb_if.i_req = 4'b0001;
    step();
    expect_gnt("to_regrant", 4'b0001, 0);
    arb_if.i_req = 4'b0000;
    step();
    expect_gnt("to_end_idle", 0, 0);
`else
    // Unbounded ownership
    bad_gnt = 0;
    bad_tmo = 0;
    arb_if.i_req = 4'b0001;
    step();
    for (int c = 0; c < 1000; c++) begin
      if (arb_if.o_gnt != 4'b0001 || arb_if.o_busy != 1'b1) bad_gnt++;
      if (arb_if.o_timeout != 1'b0) bad_tmo++;
      step();
    end
    check("hold1000_gnt_bad_cycles", bad_gnt, 0);
    check("hold1000_tmo_bad_cycles", bad_tmo, 0);
    arb_if.i_req = 4'b0000;
    step();
    expect_gnt("hold_idle", 0, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
